term_char_writer: RTL and testbench

Upstream feeder of the text-mode display. It accepts a byte stream from the terminal front end (UART receiver) with a valid/ready handshake and interprets it as terminal output. It owns the cursor and drives the display's single write port (wr_en/wr_addr/wr_data) into the 80x25 character index RAM. Supported behaviour: printable writes, CR, LF, BS, form-feed clear, line wrap and row wrap with row clearing.

---
 rtl/term_pkg.sv | 28 ++
 rtl/term_cursor.sv | 64 ++++++
 rtl/term_char_writer.sv | 183 ++++++++++++++++++
 tb/tb_term_char_writer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// rtl/term_pkg.sv - shared constants and FSM state type for the terminal character writer
// Optional feature macro: TERM_TAB_EN adds the TAB_FILL state.
package term_pkg;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;

    // Cell value for an empty cell; the display subtracts 1 to get glyph 0x20.
    localparam logic [7:0] BLANK = 8'h21;

    localparam logic [7:0] CHR_BS  = 8'h08;
    localparam logic [7:0] CHR_TAB = 8'h09;
    localparam logic [7:0] CHR_LF  = 8'h0A;
    localparam logic [7:0] CHR_FF  = 8'h0C;
    localparam logic [7:0] CHR_CR  = 8'h0D;

    typedef enum logic [2:0] {
        INIT_CLR,
        IDLE,
        CLR_ROW,
        CLR_ALL
`ifdef TERM_TAB_EN
        , TAB_FILL
`endif
    } term_state_e;

endpackage

// File: rtl/term_cursor.sv
// rtl/term_cursor.sv - cursor column/row/row-base registers with wrap logic
// Ports:
//   clk100, rst          clock, async active-high reset
//   inc_col              advance one cell; at the last column wraps to the next row
//   dec_col              step back one column (no effect at column 0)
//   col_zero             carriage return
//   next_row             line feed, column unchanged
//   home                 column and row to 0
//   col, row, row_base   current cursor; row_base = row*COLS kept without a multiplier
//   next_base            row_base of the row after the current one
//   last_col             cursor sits on column COLS-1
module term_cursor
    import term_pkg::*;
(
    input  logic        clk100,
    input  logic        rst,
    input  logic        inc_col,
    input  logic        dec_col,
    input  logic        col_zero,
    input  logic        next_row,
    input  logic        home,
    output logic [6:0]  col,
    output logic [4:0]  row,
    output logic [10:0] row_base,
    output logic [10:0] next_base,
    output logic        last_col
);

    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [10:0] ROW_STEP = 11'(COLS);

    logic last_row;

    assign last_col  = (col == LAST_COL);
    assign last_row  = (row == LAST_ROW);
    // No scrolling: the row after the bottom one is the top one.
    assign next_base = last_row ? 11'd0 : row_base + ROW_STEP;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else if (home) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else if (next_row || (inc_col && last_col)) begin
            row      <= last_row ? 5'd0 : row + 5'd1;
            row_base <= next_base;
            if (inc_col) begin
                col <= '0;
            end
        end else if (inc_col) begin
            col <= col + 7'd1;
        end else if (dec_col && (col != 7'd0)) begin
            col <= col - 7'd1;
        end else if (col_zero) begin
            col <= '0;
        end
    end

endmodule

// File: rtl/term_char_writer.sv
// rtl/term_char_writer.sv - byte stream to 80x25 character RAM writer with cursor
// Ports:
//   clk100, rst              clock, async active-high reset
//   in_valid, in_data        incoming byte; accepted when in_ready is high
//   in_ready                 high exactly while the FSM is in IDLE
//   wr_en, wr_addr, wr_data  registered index RAM write port
//   cur_col, cur_row         cursor position
// Optional feature macro: TERM_TAB_EN enables tab expansion to the next multiple of 8.
module term_char_writer
    import term_pkg::*;
(
    input  logic        clk100,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [6:0]  cur_col,
    output logic [4:0]  cur_row
);

    term_state_e state, state_d;
    logic [10:0] cnt, cnt_d;
    logic        wr_en_d;
    logic [10:0] wr_addr_d;
    logic [7:0]  wr_data_d;

    logic        inc_col, dec_col, col_zero, next_row, home;
    logic [10:0] row_base, next_base, cell_addr;
    logic        last_col;
    logic        accept;

    term_cursor u_cursor (
        .clk100    (clk100),
        .rst       (rst),
        .inc_col   (inc_col),
        .dec_col   (dec_col),
        .col_zero  (col_zero),
        .next_row  (next_row),
        .home      (home),
        .col       (cur_col),
        .row       (cur_row),
        .row_base  (row_base),
        .next_base (next_base),
        .last_col  (last_col)
    );

    assign cell_addr = row_base + {4'd0, cur_col};
    assign accept    = in_valid && in_ready;

    // Clears issue one write per cycle; cnt is the next cell offset. The state
    // holds one extra cycle while the last write is on the port, so in_ready
    // rises on the cycle right after the final write.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        inc_col   = 1'b0;
        dec_col   = 1'b0;
        col_zero  = 1'b0;
        next_row  = 1'b0;
        home      = 1'b0;

        case (state)
            INIT_CLR, CLR_ALL: begin
                if (cnt == 11'(CELLS)) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt;
                    wr_data_d = BLANK;
                    cnt_d     = cnt + 11'd1;
                end
            end
            CLR_ROW: begin
                if (cnt == 11'(COLS)) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_base + cnt;
                    wr_data_d = BLANK;
                    cnt_d     = cnt + 11'd1;
                end
            end
`ifdef TERM_TAB_EN
            TAB_FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cell_addr;
                wr_data_d = BLANK;
                inc_col   = 1'b1;
                if (last_col) begin
                    state_d = CLR_ROW;
                    cnt_d   = '0;
                end else if (cur_col[2:0] == 3'd7) begin
                    state_d = IDLE;
                end
            end
`endif
            IDLE: begin
                if (accept) begin
                    if (in_data >= 8'h20) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cell_addr;
                        wr_data_d = in_data + 8'd1;
                        inc_col   = 1'b1;
                        if (last_col) begin
                            state_d = CLR_ROW;
                            cnt_d   = '0;
                        end
                    end else begin
                        case (in_data)
                            CHR_CR: col_zero = 1'b1;
                            CHR_LF: begin
                                // First blank of the new row goes out with the accept.
                                next_row  = 1'b1;
                                wr_en_d   = 1'b1;
                                wr_addr_d = next_base;
                                wr_data_d = BLANK;
                                cnt_d     = 11'd1;
                                state_d   = CLR_ROW;
                            end
                            CHR_BS: begin
                                if (cur_col != 7'd0) begin
                                    dec_col   = 1'b1;
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = cell_addr - 11'd1;
                                    wr_data_d = BLANK;
                                end
                            end
                            CHR_FF: begin
                                home      = 1'b1;
                                wr_en_d   = 1'b1;
                                wr_addr_d = '0;
                                wr_data_d = BLANK;
                                cnt_d     = 11'd1;
                                state_d   = CLR_ALL;
                            end
`ifdef TERM_TAB_EN
                            CHR_TAB: begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = cell_addr;
                                wr_data_d = BLANK;
                                inc_col   = 1'b1;
                                if (last_col) begin
                                    state_d = CLR_ROW;
                                    cnt_d   = '0;
                                end else if (cur_col[2:0] != 3'd7) begin
                                    state_d = TAB_FILL;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = INIT_CLR;
        endcase
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state    <= INIT_CLR;
            cnt      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            in_ready <= (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_term_char_writer.sv
// tb/tb_term_char_writer.sv - randomized self-checking bench for term_char_writer
module tb_term_char_writer;

    logic        clk100 = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;

    int checks = 0;
    int failures = 0;

    // Reference model: screen cursor plus queue of expected RAM writes.
    int exp_addr[$];
    int exp_data[$];
    int mcol = 0;
    int mrow = 0;
    bit sb_en = 1'b0;
    int sb_a, sb_d;

    term_char_writer dut (
        .clk100   (clk100),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cur_col  (cur_col),
        .cur_row  (cur_row)
    );

    always #5 clk100 = ~clk100;

    function automatic void push_w(int a, int d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endfunction

    function automatic void m_newline();
        mrow = (mrow + 1) % 25;
        for (int i = 0; i < 80; i++) push_w(mrow * 80 + i, 'h21);
    endfunction

    function automatic void m_advance();
        mcol++;
        if (mcol == 80) begin
            mcol = 0;
            m_newline();
        end
    endfunction

    function automatic void model_byte(int b);
        if (b >= 32) begin
            push_w(mrow * 80 + mcol, (b + 1) % 256);
            m_advance();
        end else if (b == 13) begin
            mcol = 0;
        end else if (b == 10) begin
            m_newline();
        end else if (b == 8) begin
            if (mcol > 0) begin
                mcol--;
                push_w(mrow * 80 + mcol, 'h21);
            end
        end else if (b == 12) begin
            for (int i = 0; i < 2000; i++) push_w(i, 'h21);
            mcol = 0;
            mrow = 0;
        end
`ifdef TERM_TAB_EN
        else if (b == 9) begin
            do begin
                push_w(mrow * 80 + mcol, 'h21);
                m_advance();
            end while (mcol % 8 != 0);
        end
`endif
    endfunction

    // Every RAM write must match the next expected write, in order.
    always @(negedge clk100) begin
        if (sb_en && !rst && wr_en === 1'b1) begin
            checks++;
            if (exp_addr.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_write addr=%0d data=%h required=none", wr_addr, wr_data);
            end else begin
                sb_a = exp_addr.pop_front();
                sb_d = exp_data.pop_front();
                if (wr_addr !== 11'(sb_a) || wr_data !== 8'(sb_d)) begin
                    failures++;
                    $display("FAIL sb_write addr=%0d data=%h required addr=%0d data=%h",
                             wr_addr, wr_data, sb_a, sb_d);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 5000) begin
            @(negedge clk100);
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready_timeout byte=%h in_ready=%b required=1", b, in_ready);
        end else begin
            model_byte(int'(b));
        end
        @(negedge clk100);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while ((in_ready !== 1'b1 || exp_addr.size() != 0) && t < 10000) begin
            @(negedge clk100);
            t++;
        end
        checks++;
        if (t >= 10000) begin
            failures++;
            $display("FAIL %s_idle_timeout in_ready=%b pending=%0d required ready=1 pending=0",
                     tag, in_ready, exp_addr.size());
        end
        checks++;
        if (cur_col !== 7'(mcol) || cur_row !== 5'(mrow)) begin
            failures++;
            $display("FAIL %s_cursor col=%0d row=%0d required col=%0d row=%0d",
                     tag, cur_col, cur_row, mcol, mrow);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        sb_en = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk100);
        checks++;
        if (wr_en !== 1'b0 || in_ready !== 1'b0 || wr_addr !== 11'd0 || wr_data !== 8'd0 ||
            cur_col !== 7'd0 || cur_row !== 5'd0) begin
            failures++;
            $display("FAIL reset_values wr_en=%b in_ready=%b addr=%0d data=%h col=%0d row=%0d required all 0",
                     wr_en, in_ready, wr_addr, wr_data, cur_col, cur_row);
        end
        rst = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk100);
            if (wr_en !== 1'b1 || wr_addr !== 11'(k - 1) || wr_data !== 8'h21 || in_ready !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL init_clear bad_cycles=%0d required=0", bad);
        end
        @(negedge clk100);
        checks++;
        if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL init_ready clock2001 in_ready=%b wr_en=%b required 1 0", in_ready, wr_en);
        end
        mcol = 0;
        mrow = 0;
        sb_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        send(8'h41);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 11'd0 || wr_data !== 8'h42 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ab_first wr_en=%b addr=%0d data=%h ready=%b required 1 0 42 1",
                     wr_en, wr_addr, wr_data, in_ready);
        end
        send(8'h42);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 11'd1 || wr_data !== 8'h43 || cur_col !== 7'd2) begin
            failures++;
            $display("FAIL ab_second wr_en=%b addr=%0d data=%h col=%0d required 1 1 43 2",
                     wr_en, wr_addr, wr_data, cur_col);
        end
        wait_idle("back_to_back");
    endtask

    task automatic test_cr_lf();
        int n = 0;
        int w = 0;
        send(8'h0D);
        repeat (3) send(8'h0A);
        repeat (5) send(8'($urandom_range(32, 255)));
        wait_idle("pos_5_3");
        send(8'h0D);
        checks++;
        if (wr_en !== 1'b0 || cur_col !== 7'd0) begin
            failures++;
            $display("FAIL cr_no_write wr_en=%b col=%0d required 0 0", wr_en, cur_col);
        end
        send(8'h0A);
        checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 11'd320) begin
            failures++;
            $display("FAIL lf_first ready=%b wr_en=%b addr=%0d required 0 1 320", in_ready, wr_en, wr_addr);
        end
        while (in_ready !== 1'b1 && n < 200) begin
            if (wr_en === 1'b1) w++;
            n++;
            @(negedge clk100);
        end
        checks++;
        if (n != 80 || w != 80) begin
            failures++;
            $display("FAIL lf_busy busy_cycles=%0d writes=%0d required 80 80", n, w);
        end
        wait_idle("cr_lf");
    endtask

    task automatic test_row_wrap();
        repeat (20) send(8'h0A);
        wait_idle("to_row24");
        repeat (79) send(8'($urandom_range(32, 255)));
        send(8'($urandom_range(32, 255)));
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 11'd1999) begin
            failures++;
            $display("FAIL wrap_last_char wr_en=%b addr=%0d required 1 1999", wr_en, wr_addr);
        end
        @(negedge clk100);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 11'd0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL wrap_clear_start wr_en=%b addr=%0d ready=%b required 1 0 0", wr_en, wr_addr, in_ready);
        end
        wait_idle("row_wrap");
    endtask

    task automatic test_backspace();
        send(8'h08);
        checks++;
        if (wr_en !== 1'b0 || cur_col !== 7'd0) begin
            failures++;
            $display("FAIL bs_col0 wr_en=%b col=%0d required 0 0", wr_en, cur_col);
        end
        send(8'h0A);
        wait_idle("bs_row1");
        repeat (3) send(8'($urandom_range(32, 255)));
        send(8'h08);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 11'd82 || wr_data !== 8'h21 || cur_col !== 7'd2) begin
            failures++;
            $display("FAIL bs_col3 wr_en=%b addr=%0d data=%h col=%0d required 1 82 21 2",
                     wr_en, wr_addr, wr_data, cur_col);
        end
        wait_idle("backspace");
    endtask

    task automatic test_tab();
        send(8'h0D);
        repeat (3) send(8'($urandom_range(32, 255)));
        wait_idle("tab_pos");
        send(8'h09);
`ifdef TERM_TAB_EN
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 11'd83 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL tab_first wr_en=%b addr=%0d ready=%b required 1 83 0", wr_en, wr_addr, in_ready);
        end
        wait_idle("tab");
        checks++;
        if (cur_col !== 7'd8) begin
            failures++;
            $display("FAIL tab_col col=%0d required 8", cur_col);
        end
`else
        checks++;
        if (wr_en !== 1'b0 || cur_col !== 7'd3 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL tab_dropped wr_en=%b col=%0d ready=%b required 0 3 1", wr_en, cur_col, in_ready);
        end
        wait_idle("tab");
`endif
    endtask

    task automatic test_random();
        int r;
        logic [7:0] b;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 255));
            else if (r < 78) b = 8'h0D;
            else if (r < 86) b = 8'h0A;
            else if (r < 92) b = 8'h08;
            else if (r < 94) b = 8'h09;
            else if (r < 99) b = 8'($urandom_range(0, 31));
            else             b = 8'h0C;
            send(b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk100);
        end
        wait_idle("random");
    endtask

    task automatic test_reset_midclear();
        int t = 0;
        sb_en = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h0C;
        while (in_ready !== 1'b1 && t < 5000) begin
            @(negedge clk100);
            t++;
        end
        @(negedge clk100);
        in_valid = 1'b0;
        repeat (50) @(negedge clk100);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0 || in_ready !== 1'b0 || cur_col !== 7'd0 || cur_row !== 5'd0) begin
            failures++;
            $display("FAIL midclear_abort wr_en=%b ready=%b col=%0d row=%0d required 0 0 0 0",
                     wr_en, in_ready, cur_col, cur_row);
        end
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk100);
        rst = 1'b0;
        for (int i = 0; i < 2000; i++) push_w(i, 'h21);
        mcol = 0;
        mrow = 0;
        sb_en = 1'b1;
        wait_idle("midclear_restart");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_cr_lf();
        test_row_wrap();
        test_backspace();
        test_tab();
        test_random();
        test_reset_midclear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
